d7s_scan_ctrl: RTL

Scan controller for the board's multiplexed 7-segment display with three common-driver transistors. It accepts BCD values from a requester through a valid/ready handshake and double-buffers them, applying new values only at frame boundaries so a frame never tears. It time-multiplexes the digits with a programmable slot length and inserts a blanking dead time between digits to suppress ghosting. It drives the segment lines and the one-hot transistor select directly to the top-level output pins.

---
 rtl/d7s_scan_ctrl.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/d7s_scan_ctrl.sv
// ---------------------------------------------------------------------------
// d7s_scan_ctrl
//   Scan controller for a multiplexed 7-segment display that has one
//   common-driver transistor per digit. BCD digits arrive over a valid/ready
//   handshake and go into a pending buffer. They are copied into the displayed
//   (shadow) register only at a frame boundary, so a frame never shows a mix
//   of old and new digits. Each digit slot starts with a blanking dead time
//   that suppresses ghosting. The rest of the slot drives the digit.
//
//   Optional build macro: D7S_DIM_EN
//     Adds the brightness[3:0] input and a free-running 4-bit PWM counter.
//     During DRIVE the outputs are gated off whenever pwm >= brightness.
//
//   Ports
//     clk         system clock
//     rst_n       asynchronous active-low reset
//     en          scan enable; 0 forces IDLE
//     wr_valid    requester has new digits
//     wr_ready    pending buffer is empty
//     wr_data     BCD digits, [3:0] = digit 0 (least significant)
//     lzb_en      leading-zero blanking enable
//     brightness  PWM duty in 1/16 steps (D7S_DIM_EN only)
//     transistor  one-hot digit select, active high
//     d7sp        segments {g,f,e,d,c,b,a}, active high
//     frame_done  one-cycle pulse in the last DRIVE cycle of the last digit
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | scan stopped, outputs off, pending copied straight to shadow
//   BLANK  | dead time at the start of a slot, outputs off
//   DRIVE  | selected digit lit for the remainder of the slot
// ---------------------------------------------------------------------------
module d7s_scan_ctrl #(
    parameter int N_DIGITS  = 3,
    parameter int SCAN_DIV  = 10000,
    parameter int BLANK_CYC = 16,
    parameter int CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [4*N_DIGITS-1:0] wr_data,
    input  logic                  lzb_en,
`ifdef D7S_DIM_EN
    input  logic [3:0]            brightness,
`endif
    output logic [N_DIGITS-1:0]   transistor,
    output logic [6:0]            d7sp,
    output logic                  frame_done
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST       = IDX_W'(N_DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_idx_nxt;

    logic [4*N_DIGITS-1:0] r_pend;
    logic                  r_pend_full;
    logic [4*N_DIGITS-1:0] r_shadow;
    logic [4*N_DIGITS-1:0] w_shadow_nxt;
    logic                  w_boundary;
    logic                  w_accept;
    logic                  w_xfer;

    logic [N_DIGITS-1:0]   r_transistor;
    logic [6:0]            r_d7sp;
    logic                  r_frame_done;
    logic [N_DIGITS-1:0]   w_tr_nxt;
    logic [6:0]            w_seg_nxt;
    logic                  w_fd_nxt;

    logic [3:0]            w_digit;
    logic [N_DIGITS-1:0]   w_sel;
    logic [N_DIGITS-1:0]   w_lz_blank;
    logic                  w_upper_zero;
    logic                  w_slot_blank;
    logic                  w_dim_on;
    logic                  w_lit;

    function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'b0111111;
            4'd1:    seg = 7'b0000110;
            4'd2:    seg = 7'b1011011;
            4'd3:    seg = 7'b1001111;
            4'd4:    seg = 7'b1100110;
            4'd5:    seg = 7'b1101101;
            4'd6:    seg = 7'b1111101;
            4'd7:    seg = 7'b0000111;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1101111;
            default: seg = 7'b1000000;  // non-BCD codes show a dash
        endcase
        return seg;
    endfunction

`ifdef D7S_DIM_EN
    logic [3:0] r_pwm;
    logic [3:0] w_pwm_nxt;

    assign w_pwm_nxt = r_pwm + 4'd1;
    // Compare against the PWM value that will be current when the registered
    // outputs are visible, so the duty is exactly brightness/16.
    assign w_dim_on  = (w_pwm_nxt < brightness);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm <= 4'd0;
        end else begin
            r_pwm <= w_pwm_nxt;
        end
    end
`else
    assign w_dim_on = 1'b1;
`endif

    // IDLE behaves as a permanent frame boundary: pending data is applied
    // immediately because nothing is being displayed.
    assign w_boundary   = (r_state == ST_IDLE) ||
                          ((r_state == ST_BLANK) && (r_idx == '0) && (r_cnt == '0));
    assign w_accept     = wr_valid && !r_pend_full;
    assign w_xfer       = r_pend_full && w_boundary;
    assign w_shadow_nxt = w_xfer ? r_pend : r_shadow;
    assign wr_ready     = !r_pend_full;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        if (!en) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_BLANK;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
                ST_BLANK: begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == CNT_BLANK_LAST) begin
                        w_state_nxt = ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (r_cnt == CNT_SLOT_LAST) begin
                        w_state_nxt = ST_BLANK;
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            endcase
        end
    end

    // Output values are computed from the next state and next shadow so the
    // registered select and segments change together on the same edge.
    always_comb begin
        w_digit      = 4'd0;
        w_sel        = '0;
        w_lz_blank   = '0;
        w_upper_zero = 1'b1;
        w_slot_blank = 1'b0;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            w_upper_zero  = w_upper_zero && (w_shadow_nxt[4*i +: 4] == 4'd0);
            w_lz_blank[i] = w_upper_zero;
        end
        for (int i = 0; i < N_DIGITS; i++) begin
            if (w_idx_nxt == IDX_W'(i)) begin
                w_digit      = w_shadow_nxt[4*i +: 4];
                w_sel[i]     = 1'b1;
                w_slot_blank = lzb_en && w_lz_blank[i];
            end
        end
        w_lit     = (w_state_nxt == ST_DRIVE) && !w_slot_blank && w_dim_on;
        w_tr_nxt  = w_lit ? w_sel : '0;
        w_seg_nxt = w_lit ? seg_decode(w_digit) : 7'd0;
        w_fd_nxt  = (w_state_nxt == ST_DRIVE) && (w_idx_nxt == IDX_LAST) &&
                    (w_cnt_nxt == CNT_SLOT_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_pend       <= '0;
            r_pend_full  <= 1'b0;
            r_shadow     <= '0;
            r_transistor <= '0;
            r_d7sp       <= 7'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_shadow     <= w_shadow_nxt;
            if (w_xfer) begin
                r_pend_full <= 1'b0;
            end else if (w_accept) begin
                r_pend      <= wr_data;
                r_pend_full <= 1'b1;
            end
            r_transistor <= w_tr_nxt;
            r_d7sp       <= w_seg_nxt;
            r_frame_done <= w_fd_nxt;
        end
    end

    assign transistor = r_transistor;
    assign d7sp       = r_d7sp;
    assign frame_done = r_frame_done;

endmodule
